// File: rtl/uart_pkg.sv
// Shared UART types and helpers, used by the transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int unsigned DATA_BITS = 8;

    // Clock cycles per bit; fractional baud error is truncated.
    function automatic int unsigned calc_div(input int unsigned clk_rate,
                                             input int unsigned baud_rate);
        return clk_rate / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period counter: counts 0..DIV-1 and flags the last cycle of a bit.
// CLEAR_I forces the count to 0 so each new state starts a full bit period.
module uart_tx_baud_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic CLEAR_I,
    output logic TICK_O
);

    localparam int unsigned     CW   = $clog2(DIV);
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign TICK_O = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (CLEAR_I || TICK_O) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input; frame is 10*DIV cycles after the handshake.
// READY_O is high only while idle, so a held VALID_I gives one idle cycle between frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_RATE  = 100000000,
    parameter int unsigned BAUD_RATE = 3000000
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic [7:0] DATA_I,
    input  logic       VALID_I,
    output logic       READY_O,
    output logic       TX_O,
    output logic       DONE_O
);

    localparam int unsigned DIV = calc_div(CLK_RATE, BAUD_RATE);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx: CLK_RATE/BAUD_RATE must be at least 2");
    end

    tx_state_t  state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       tx_q, tx_d;
    logic       baud_clear;
    logic       baud_tick;

    // Idle keeps the counter parked at 0 so START always lasts a full bit.
    assign baud_clear = (state_d != state_q) || (state_q == IDLE);

    uart_tx_baud_gen #(
        .DIV (DIV)
    ) u_baud_gen (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .CLEAR_I (baud_clear),
        .TICK_O  (baud_tick)
    );

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = '0;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (VALID_I) begin
                    state_d = START;
                    shift_d = DATA_I;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                bit_d = bit_q;
                if (baud_tick) begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // TX is registered from the next state so the line moves on the same edge as the FSM.
    always_comb begin
        tx_d    = 1'b1;
        READY_O = (state_q == IDLE);
        DONE_O  = (state_q == STOP) && baud_tick;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign TX_O = tx_q;

endmodule
